// File: rtl/layer_sequencer_if.sv
// Control/status bundle between the layer sequencer and the host/engine side.
// master: the sequencer (drives enables, SRAM select, status).
// slave : host and layer engines (drive start/abort/valid).
interface layer_sequencer_if #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 2,
    parameter int CNT_W      = 16
);
    logic                  start;
    logic                  abort;
    logic [NUM_LAYERS-1:0] layer_valid;
    logic [NUM_LAYERS-1:0] layer_en;
    logic [IDX_W-1:0]      cur_layer;
    logic                  rd_group_b;
    logic                  wr_group_b;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [IDX_W-1:0]      err_layer;
    logic [CNT_W-1:0]      layer_cycles;

    modport master (
        input  start, abort, layer_valid,
        output layer_en, cur_layer, rd_group_b, wr_group_b,
               busy, done, err, err_layer, layer_cycles
    );

    modport slave (
        output start, abort, layer_valid,
        input  layer_en, cur_layer, rd_group_b, wr_group_b,
               busy, done, err, err_layer, layer_cycles
    );
endinterface

// File: rtl/layer_sequencer.sv
// Layer scheduler: enables one layer engine at a time, waits for its valid,
// drains for a fixed gap, steers SRAM ownership and ping-pong groups, and
// flags per-layer timeouts.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// RUN    | layer_en[idx] high, counting cycles until layer_valid[idx]
// DRAIN  | enables low for DRAIN_CYC cycles so the engine returns to idle
// FINISH | all layers complete, done held; start restarts at layer 0
// ERROR  | layer timed out, err held until abort or reset
module layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 2,
    parameter int DRAIN_CYC  = 2,
    parameter int TIMEOUT    = 4095,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    layer_sequencer_if.master  bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LAYERS - 1);
    // Unused when TIMEOUT is 0; guarded so the subtraction never wraps.
    localparam logic [CNT_W-1:0] TO_LAST    = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, FINISH, ERROR} state_t;

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      run_cnt_q, run_cnt_d;
    logic [DW-1:0]         drain_cnt_q, drain_cnt_d;
    logic [NUM_LAYERS-1:0] layer_en_q, layer_en_d;
    logic [IDX_W-1:0]      cur_layer_q, cur_layer_d;
    logic                  rd_b_q, rd_b_d;
    logic                  wr_b_q, wr_b_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      err_layer_q, err_layer_d;
    logic [CNT_W-1:0]      cycles_q, cycles_d;
    logic                  launch;
    logic [IDX_W-1:0]      launch_idx;

    // State and all registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            run_cnt_q   <= '0;
            drain_cnt_q <= '0;
            layer_en_q  <= '0;
            cur_layer_q <= '0;
            rd_b_q      <= 1'b0;
            wr_b_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_layer_q <= '0;
            cycles_q    <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            run_cnt_q   <= run_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            layer_en_q  <= layer_en_d;
            cur_layer_q <= cur_layer_d;
            rd_b_q      <= rd_b_d;
            wr_b_q      <= wr_b_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_layer_q <= err_layer_d;
            cycles_q    <= cycles_d;
        end
    end

    // Next-state and next-output decode; abort overrides every transition.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        run_cnt_d   = run_cnt_q;
        drain_cnt_d = drain_cnt_q;
        layer_en_d  = layer_en_q;
        cur_layer_d = cur_layer_q;
        rd_b_d      = rd_b_q;
        wr_b_d      = wr_b_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        err_layer_d = err_layer_q;
        cycles_d    = cycles_q;
        launch      = 1'b0;
        launch_idx  = '0;

        if (bus.abort) begin
            state_d     = IDLE;
            layer_en_d  = '0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
            err_d       = 1'b0;
            run_cnt_d   = '0;
            drain_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE, FINISH: begin
                    if (bus.start) begin
                        launch     = 1'b1;
                        launch_idx = '0;
                    end
                end
                RUN: begin
                    // Valid takes precedence over a timeout in the same cycle.
                    if (bus.layer_valid[idx_q]) begin
                        state_d     = DRAIN;
                        layer_en_d  = '0;
                        drain_cnt_d = '0;
                        cycles_d    = (run_cnt_q == '1) ? '1 : run_cnt_q + 1'b1;
                    end else if (TIMEOUT != 0 && run_cnt_q == TO_LAST) begin
                        state_d     = ERROR;
                        layer_en_d  = '0;
                        busy_d      = 1'b0;
                        err_d       = 1'b1;
                        err_layer_d = idx_q;
                    end else if (run_cnt_q != '1) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == DRAIN_LAST) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = FINISH;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            launch     = 1'b1;
                            launch_idx = idx_q + 1'b1;
                        end
                    end else begin
                        drain_cnt_d = drain_cnt_q + 1'b1;
                    end
                end
                ERROR: begin
                    state_d = ERROR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // SRAM select and ping-pong groups move only when a new enable rises.
        if (launch) begin
            state_d     = RUN;
            idx_d       = launch_idx;
            run_cnt_d   = '0;
            drain_cnt_d = '0;
            layer_en_d  = NUM_LAYERS'(1) << launch_idx;
            cur_layer_d = launch_idx;
            wr_b_d      = launch_idx[0];
            rd_b_d      = (launch_idx != '0) & ~launch_idx[0];
            busy_d      = 1'b1;
            done_d      = 1'b0;
        end
    end

    assign bus.layer_en     = layer_en_q;
    assign bus.cur_layer    = cur_layer_q;
    assign bus.rd_group_b   = rd_b_q;
    assign bus.wr_group_b   = wr_b_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.err_layer    = err_layer_q;
    assign bus.layer_cycles = cycles_q;
endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
Top-level layer scheduler for the CNN accelerator. Enables the layer engines (unshuffle, conv1, conv2, conv3) one at a time and waits for each engine's valid. Between layers it drains so the engine returns to IDLE. It also drives the SRAM port-ownership select and the ping-pong read/write group flags for SRAM groups A/B, and reports per-layer cycle counts and timeout errors.

Parameters:
NUM_LAYERS, 4, number of layer engines sequenced (index 0..NUM_LAYERS-1)
IDX_W, 2, width of layer index (clog2(NUM_LAYERS))
DRAIN_CYC, 2, cycles enable is held low between layers (>=1)
TIMEOUT, 4095, max RUN cycles per layer before error; 0 disables timeout
CNT_W, 16, width of run-cycle counter and layer_cycles

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
start  input  1  begin sequence at layer 0; honoured only in IDLE or FINISH
abort  input  1  return to IDLE from any state
layer_valid  input  NUM_LAYERS  done flag from each engine (level)
layer_en  output  NUM_LAYERS  one-hot engine enable, registered
cur_layer  output  IDX_W  layer currently owning SRAM ports (mux select)
rd_group_b  output  1  1: active layer reads group B, 0: reads group A
wr_group_b  output  1  1: active layer writes group B, 0: writes group A
busy  output  1  high in RUN or DRAIN
done  output  1  high in FINISH
err  output  1  high in ERROR
err_layer  output  IDX_W  layer index that timed out
layer_cycles  output  CNT_W  RUN-cycle count of most recently completed layer, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; run_cnt, drain_cnt, idx = 0.
- All outputs registered. States: IDLE, RUN, DRAIN, FINISH, ERROR.
- Priority each cycle: rst_n low > abort > normal transitions.
- abort=1 in any state: next state IDLE. layer_en, busy, done and err go to 0 at the next edge. cur_layer, err_layer and layer_cycles hold their values.
- IDLE: start=1 → RUN with idx=0. layer_en=1<<0, cur_layer=0 and busy=1 at next edge (1-cycle latency from start).
- RUN:
  - layer_en[idx]=1; run_cnt increments each cycle from 0.
  - Only layer_valid[idx] is sampled; all other valid bits are ignored.
  - layer_valid[idx]=1 at run_cnt=k → layer_cycles <= min(k+1, 2^CNT_W-1), layer_en <= 0, state DRAIN, drain_cnt <= 0.
  - Else, if TIMEOUT!=0 and run_cnt==TIMEOUT-1 → state ERROR, err <= 1, err_layer <= idx, layer_en <= 0, busy <= 0.
  - If valid and timeout occur in the same cycle, valid wins.
  - run_cnt saturates at all-ones.
- DRAIN:
  - layer_en all 0; drain_cnt counts 0..DRAIN_CYC-1.
  - At drain_cnt==DRAIN_CYC-1: if idx==NUM_LAYERS-1 → FINISH (busy 0, done 1). Otherwise idx+1 → RUN, and layer_en[idx+1] rises at the next edge.
  - Enable gap is exactly DRAIN_CYC cycles.
- cur_layer, rd_group_b and wr_group_b update only on the edge where the new layer_en rises, and stay stable through DRAIN. Group mapping:
  - wr_group_b = idx[0].
  - rd_group_b = (idx!=0) & ~idx[0].
  - Result: layer0 writes A; layer1 reads A, writes B; layer2 reads B, writes A; layer3 reads A, writes B.
- FINISH: done=1 held. start=1 → RUN layer 0 with done <= 0 (restart). start is ignored in RUN, DRAIN and ERROR.
- ERROR: err=1 held; exits only via abort or reset.
- start and abort in the same cycle: abort wins, state IDLE.
- Reset asserted mid-run: all outputs 0 at the next edge regardless of state.

Test Plan:
- Normal run, DRAIN_CYC=2: start at cycle 0 → layer_en=0001 at cycle 1. Valid[0] at cycle 10 → layer_en 0 at 11–12, 0010 at 13, layer_cycles=10. Repeat for layers 1–3 → done=1, busy=0; check cur_layer/group flags per layer (0/x/0, 1/0/1, 2/1/0, 3/0/1).
- Spurious valid: layer_valid=1110 while layer 0 runs → no transition. Valid[0] later → advance normally.
- Timeout, TIMEOUT=8: layer 2 never raises valid → after 8 RUN cycles err=1, err_layer=2, layer_en=0. start ignored; abort → IDLE, err=0.
- Valid on last timeout cycle (run_cnt=7, TIMEOUT=8) → DRAIN, no error, layer_cycles=8.
- Abort in DRAIN of layer 1, plus start+abort in the same cycle → IDLE, layer_en=0, no layer started. Then start → restart at layer 0.
- Restart from FINISH: start → done clears at the next edge, layer_en=0001. rst_n low mid-layer-2 → all outputs 0 next edge.
